// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch front end, instruction memory, DECODE and EXECUTE.
interface fetch_queue_if;
  logic        stall;
  logic        do_branch;
  logic [31:0] pc_effective;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        rw;
  logic [1:0]  access_size;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  modport master (
    input  stall, do_branch, pc_effective, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_addr, rw, access_size, out_valid, pc_out, instr_out
  );

  modport slave (
    output stall, do_branch, pc_effective, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_addr, rw, access_size, out_valid, pc_out, instr_out
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC issue with bounded in-order reads,
// a DEPTH-entry instruction queue toward DECODE, and branch flush with stale-response drop.
module fetch_queue #(
  parameter logic [31:0] BASE_ADDR       = 32'h8002_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int unsigned QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   qpc_q  [DEPTH];
  logic [31:0]   qins_q [DEPTH];
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ifpc_q [MAX_OUTSTANDING];
  logic [IW-1:0] ifrd_q, ifrd_d, ifwr_q, ifwr_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   hpc_q, hpc_d, hins_q, hins_d;
  logic [31:0]   level, target, rsp_pc;
  logic          req_valid, fire, rsp, push, pop, out_valid;

  function automatic logic [IW-1:0] if_next(input logic [IW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + IW'(1);
  endfunction

  always_comb begin
    level     = 32'(count_q) + 32'(outst_q);
    target    = bus.pc_effective & ~32'd3;
    rsp       = bus.imem_rsp_valid;
    rsp_pc    = ifpc_q[ifrd_q];
    req_valid = !reset && !bus.do_branch && (level < DEPTH) && (32'(outst_q) < MAX_OUTSTANDING);
    fire      = req_valid && bus.imem_req_ready;
    out_valid = (count_q != '0) && !bus.do_branch;
    pop       = out_valid && !bus.stall;
    push      = rsp && (drop_q == '0) && !bus.do_branch;

    pc_d    = pc_q;
    ifwr_d  = ifwr_q;
    ifrd_d  = rsp ? if_next(ifrd_q) : ifrd_q;
    outst_d = outst_q + OW'(fire) - OW'(rsp);
    drop_d  = drop_q;
    if (fire) begin
      pc_d   = pc_q + 32'd4;
      ifwr_d = if_next(ifwr_q);
    end
    if (bus.do_branch) begin
      pc_d   = target;
      // Stale reads remain counted in outstanding, so every read still in flight
      // after this edge is stale; earlier drops are already part of that count.
      drop_d = outst_q - OW'(rsp);
    end else if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.do_branch) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + QW'(1);
      if (push) tail_d = tail_q + QW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // Head is mirrored in registers so outputs hold their last value when the queue empties.
    hpc_d  = hpc_q;
    hins_d = hins_q;
    if (count_d != '0) begin
      if (push && (tail_q == head_d)) begin
        hpc_d  = rsp_pc;
        hins_d = bus.imem_rsp_data;
      end else begin
        hpc_d  = qpc_q[head_d];
        hins_d = qins_q[head_d];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= BASE_ADDR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ifrd_q  <= '0;
      ifwr_q  <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      hpc_q   <= '0;
      hins_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ifrd_q  <= ifrd_d;
      ifwr_q  <= ifwr_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      hpc_q   <= hpc_d;
      hins_q  <= hins_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      qpc_q[tail_q]  <= rsp_pc;
      qins_q[tail_q] <= bus.imem_rsp_data;
    end
    if (fire) ifpc_q[ifwr_q] <= pc_q;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.rw             = 1'b1;
  assign bus.access_size    = 2'b00;
  assign bus.out_valid      = out_valid;
  assign bus.pc_out         = hpc_q;
  assign bus.instr_out      = hins_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: program-order reference model with a behavioural memory.
module tb_fetch_queue;
  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  fetch_queue_if bus ();

  fetch_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  ent_t        sb[$];
  logic [31:0] mem_q[$];
  logic [31:0] model_pc = BASE;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, then update the reference model from the handshakes.
  task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                      input logic rdy, input logic rsp_en);
    ent_t e;
    logic ok;
    @(negedge clock);
    reset              = rst;
    bus.stall          = st;
    bus.do_branch      = br;
    bus.pc_effective   = tgt;
    bus.imem_req_ready = rdy;
    if (!rst && rsp_en && (mem_q.size() > 0)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    if (reset) begin
      check("reqv_in_reset", 32'(bus.imem_req_valid), 0);
      sb.delete();
      mem_q.delete();
      model_pc     = BASE;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && !bus.do_branch) begin
        check("req_hold_valid", 32'(bus.imem_req_valid), 1);
        check("req_hold_addr", bus.imem_addr, prev_addr);
      end
      if (bus.do_branch) check("reqv_on_branch", 32'(bus.imem_req_valid), 0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("issue_addr", bus.imem_addr, model_pc);
        e.pc  = model_pc;
        e.ins = memf(model_pc);
        sb.push_back(e);
        mem_q.push_back(bus.imem_addr);
        ok = (mem_q.size() + 32'(bus.imem_rsp_valid)) <= MAXO;
        check("outstanding_limit", 32'(ok), 1);
        ok = sb.size() <= DEPTH;
        check("queue_overflow", 32'(ok), 1);
        model_pc = model_pc + 32'd4;
      end
      prev_pending = bus.imem_req_valid && !bus.imem_req_ready;
      prev_addr    = bus.imem_addr;
      if (bus.do_branch) begin
        sb.delete();
        model_pc = tgt & ~32'd3;
      end
    end
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp_pc);
    int unsigned i = 0;
    while (!bus.out_valid && i < 20) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      i++;
    end
    check({name, "_valid"}, 32'(bus.out_valid), 1);
    check(name, bus.pc_out, exp_pc);
  endtask

  task automatic drain();
    int unsigned i = 0;
    while ((sb.size() > 0 || mem_q.size() > 0) && i < 60) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      i++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: every instruction DECODE consumes must match the scoreboard head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && bus.out_valid && !bus.stall) begin
        if (sb.size() == 0) begin
          check("unexpected_out", bus.pc_out, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check("out_pc", bus.pc_out, e.pc);
          check("out_instr", bus.instr_out, e.ins);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stall          = 1'b0;
    bus.do_branch      = 1'b0;
    bus.pc_effective   = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_instr_out", bus.instr_out, 0);
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);

    // Fill with DECODE stalled.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("first_addr", bus.imem_addr, BASE);
    check("lat_e0_valid", 32'(bus.out_valid), 0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("lat_e1_valid", 32'(bus.out_valid), 0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("lat_e2_valid", 32'(bus.out_valid), 1);
    check("lat_e2_pc", bus.pc_out, BASE);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("full_req_valid", 32'(bus.imem_req_valid), 0);
    check("full_out_valid", 32'(bus.out_valid), 1);
    check("full_head_pc", bus.pc_out, BASE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Memory not ready: request held at the next sequential PC.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("ready0_req_valid", 32'(bus.imem_req_valid), 1);
      check("ready0_addr", bus.imem_addr, 32'h8002_0010);
      check("ready0_out_valid", 32'(bus.out_valid), 0);
    end

    // Redirect with two reads in flight.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h8002_0103, 1'b1, 1'b0);
    wait_out("branch_pc", 32'h8002_0100);

    // Redirect coinciding with a response, two outstanding.
    drain();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h8003_0000, 1'b1, 1'b1);
    wait_out("rsp_branch_pc", 32'h8003_0000);

    // Reset with queued entries and reads in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("prst_out_valid", 32'(bus.out_valid), 0);
    check("prst_addr", bus.imem_addr, BASE);
    check("prst_req_valid", 32'(bus.imem_req_valid), 1);
    check("prst_pc_out", bus.pc_out, 0);
    wait_out("prst_first_pc", BASE);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           BASE + $urandom_range(0, 255), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain();
    check("end_out_valid", 32'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
